// File: rtl/router_sync_n.sv
// Router synchroniser: address latch/decode, addressed-full mux, per-channel valid and idle-timeout soft reset.
// Comb write_enb/fifo_full/vld_out; 1-cycle registered pulses; no backpressure. Option: SYNC_TIMEOUT_STATUS_EN.
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int TIMEOUT = 30,
    localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
`ifdef SYNC_TIMEOUT_STATUS_EN
    ,
    input  logic              clear_status,
    output logic [NUM_CH-1:0] timeout_flag
`endif
);

    logic [ADDR_W-1:0] addr_reg;
    logic              addr_valid;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] idle;
    logic [NUM_CH-1:0] terminal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_reg   <= '0;
            addr_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else if (detect_add) begin
            addr_reg   <= data_in;
            addr_valid <= (32'(data_in) < NUM_CH);
            addr_err   <= (32'(data_in) >= NUM_CH);
        end else begin
            addr_err   <= 1'b0;
        end
    end

    // Compare-based decode keeps out-of-range addresses from indexing past the vectors.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_valid && (32'(addr_reg) == i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;
    assign idle    = vld_out & ~read_enb;

    always_comb begin
        terminal = '0;
        for (int i = 0; i < NUM_CH; i++)
            terminal[i] = idle[i] && (cnt[i] == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            soft_reset <= '0;
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
        end else begin
            soft_reset <= terminal;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!idle[i] || terminal[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

`ifdef SYNC_TIMEOUT_STATUS_EN
    // Set beats clear when both land on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timeout_flag <= '0;
        else
            timeout_flag <= terminal | (timeout_flag & ~{NUM_CH{clear_status}});
    end
`endif

endmodule
